// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI flash read master.
// Frame layout: 8-bit opcode, 24-bit address, 32 data bits clocked in from the flash.
package spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAKE_SHIFT,
    WAKE_GAP,
    SHIFT,
    DONE
  } state_t;

  localparam logic [7:0] READ_CMD_DEF = 8'h03;
  localparam logic [7:0] WAKE_CMD_DEF = 8'hAB;

  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DATA_BITS  = 32;
  localparam int FRAME_BITS = 64;

endpackage

// File: rtl/spi_clk_div.sv
// SCK timebase: while run is high, emits a rise_en then a fall_en pulse every HALF_PERIOD clocks.
// Dropping run rewinds the phase, so every frame starts with a full low half-period.
module spi_clk_div #(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic rise_en,
  output logic fall_en
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt;
  logic          phase;
  logic          wrap;

  assign wrap    = run && (cnt == LAST);
  assign rise_en = wrap && !phase;
  assign fall_en = wrap && phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!run) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI flash master: one READ of a 32-bit word per request, with an optional
// one-time release-from-power-down command before the first read after reset.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int         HALF_PERIOD = 2,
  parameter logic [7:0] READ_CMD    = READ_CMD_DEF,
  parameter bit         WAKE_EN     = 1'b1,
  parameter logic [7:0] WAKE_CMD    = WAKE_CMD_DEF,
  parameter int         WAKE_WAIT   = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic        SPI_SCK,
  output logic        SPI_SS,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO,
  output logic        addr_buffer_free,
  input  logic        addr_en,
  input  logic [23:0] addr_data,
  output logic        rd_data_available,
  input  logic        rd_ack,
  output logic [31:0] rd_data
);

  localparam int             GW       = $clog2(WAKE_WAIT + 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(WAKE_WAIT - 1);
  localparam logic [5:0]     RX_FIRST = 6'(CMD_BITS + ADDR_BITS);

  state_t        state;
  logic [5:0]    bit_cnt;
  logic [31:0]   tx_sr;
  logic [23:0]   addr_q;
  logic [GW-1:0] gap_cnt;
  logic          wake_pending;
  logic          run;
  logic          rise_en;
  logic          fall_en;
  logic [5:0]    last_bit;

  assign run      = (state == SHIFT) || (state == WAKE_SHIFT);
  assign last_bit = (state == SHIFT) ? 6'(FRAME_BITS - 1) : 6'(CMD_BITS - 1);

  spi_clk_div #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_clk_div (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .rise_en(rise_en),
    .fall_en(fall_en)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      SPI_SS            <= 1'b1;
      SPI_SCK           <= 1'b0;
      SPI_MOSI          <= 1'b0;
      addr_buffer_free  <= 1'b1;
      rd_data_available <= 1'b0;
      rd_data           <= '0;
      wake_pending      <= 1'b1;
      bit_cnt           <= '0;
      tx_sr             <= '0;
      addr_q            <= '0;
      gap_cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (addr_en) begin
            addr_buffer_free <= 1'b0;
            addr_q           <= addr_data;
            SPI_SS           <= 1'b0;
            bit_cnt          <= '0;
            if (WAKE_EN && wake_pending) begin
              state    <= WAKE_SHIFT;
              SPI_MOSI <= WAKE_CMD[7];
              tx_sr    <= {WAKE_CMD[6:0], 25'b0};
            end else begin
              state    <= SHIFT;
              SPI_MOSI <= READ_CMD[7];
              tx_sr    <= {READ_CMD[6:0], addr_data, 1'b0};
            end
          end
        end

        // tx_sr back-fills with zeros, so MOSI drops to 0 once opcode and address are out
        WAKE_SHIFT, SHIFT: begin
          if (rise_en) begin
            SPI_SCK <= 1'b1;
            if (state == SHIFT && bit_cnt >= RX_FIRST)
              rd_data <= {rd_data[30:0], SPI_MISO};
          end
          if (fall_en) begin
            SPI_SCK <= 1'b0;
            if (bit_cnt == last_bit) begin
              SPI_SS   <= 1'b1;
              SPI_MOSI <= 1'b0;
              if (state == SHIFT) begin
                state             <= DONE;
                rd_data_available <= 1'b1;
              end else begin
                state        <= WAKE_GAP;
                wake_pending <= 1'b0;
                gap_cnt      <= '0;
              end
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              SPI_MOSI <= tx_sr[31];
              tx_sr    <= {tx_sr[30:0], 1'b0};
            end
          end
        end

        WAKE_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= SHIFT;
            SPI_SS   <= 1'b0;
            bit_cnt  <= '0;
            SPI_MOSI <= READ_CMD[7];
            tx_sr    <= {READ_CMD[6:0], addr_q, 1'b0};
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        DONE: begin
          if (rd_ack) begin
            rd_data_available <= 1'b0;
            addr_buffer_free  <= 1'b1;
            state             <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: instance 0 runs HALF_PERIOD=2 with wake, instance 1 HALF_PERIOD=1 without.
// Each instance talks to a small mode-0 flash model that records MOSI and returns a preset word.
module tb_spi_master;

  logic clk;
  logic [1:0] rst;
  logic [1:0] sck, ss, mosi, miso;
  logic [1:0] free, avail, addr_en, rd_ack;
  logic [1:0][23:0] addr_d;
  logic [1:0][31:0] rdd;
  logic [1:0][31:0] resp;
  logic [1:0][63:0] mosi_log;
  logic [1:0][7:0]  rcnt_a;

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0]  rcnt;
    logic [63:0] sr;

    spi_master #(
      .HALF_PERIOD((g == 0) ? 2 : 1),
      .READ_CMD   (8'h03),
      .WAKE_EN    ((g == 0) ? 1'b1 : 1'b0),
      .WAKE_CMD   (8'hAB),
      .WAKE_WAIT  (64)
    ) u_dut (
      .clk              (clk),
      .reset            (rst[g]),
      .SPI_SCK          (sck[g]),
      .SPI_SS           (ss[g]),
      .SPI_MOSI         (mosi[g]),
      .SPI_MISO         (miso[g]),
      .addr_buffer_free (free[g]),
      .addr_en          (addr_en[g]),
      .addr_data        (addr_d[g]),
      .rd_data_available(avail[g]),
      .rd_ack           (rd_ack[g]),
      .rd_data          (rdd[g])
    );

    // Falling SS (SCK low) starts a frame; each rising SCK counts a bit and captures MOSI.
    always @(posedge sck[g] or negedge ss[g]) begin
      if (!sck[g]) begin
        rcnt <= 8'd0;
        sr   <= 64'd0;
      end else begin
        rcnt <= rcnt + 8'd1;
        sr   <= {sr[62:0], mosi[g]};
      end
    end

    assign miso[g]     = (rcnt >= 8'd32 && rcnt < 8'd64) ? resp[g][5'(8'd63 - rcnt)] : 1'b0;
    assign mosi_log[g] = sr;
    assign rcnt_a[g]   = rcnt;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input int g, input logic [23:0] a);
    check($sformatf("free_before_req%0d", g), 64'(free[g]), 64'd1);
    @(negedge clk);
    addr_en[g] = 1'b1;
    addr_d[g]  = a;
    tick();
    addr_en[g] = 1'b0;
    check($sformatf("free_drop%0d", g), 64'(free[g]), 64'd0);
  endtask

  task automatic wait_ss(input int g, input logic lvl, output int n);
    n = 0;
    while (ss[g] !== lvl && n < 5000) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_avail(input int g, output int n);
    n = 0;
    while (avail[g] !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
  endtask

  task automatic ack(input int g);
    @(negedge clk);
    rd_ack[g] = 1'b1;
    tick();
    rd_ack[g] = 1'b0;
    check($sformatf("avail_after_ack%0d", g), 64'(avail[g]), 64'd0);
    check($sformatf("free_after_ack%0d", g), 64'(free[g]), 64'd1);
  endtask

  // Wake frame, 64-clock gap, then read frame; timed from the accept edge.
  task automatic wake_then_read(input logic [23:0] a, input logic [31:0] word, input string tag);
    int n;
    resp[0] = word;
    request(0, a);
    wait_ss(0, 1'b1, n);
    check({tag, "_wake_len_clk"}, 64'(n), 64'd32);
    check({tag, "_wake_bits"}, 64'(rcnt_a[0]), 64'd8);
    check({tag, "_wake_cmd"}, 64'(mosi_log[0][7:0]), 64'hAB);
    wait_ss(0, 1'b0, n);
    check({tag, "_wake_gap"}, 64'(n), 64'd64);
    wait_avail(0, n);
    check({tag, "_read_lat"}, 64'(n), 64'd256);
    check({tag, "_mosi"}, mosi_log[0], {8'h03, a, 32'h0});
    check({tag, "_data"}, 64'(rdd[0]), 64'(word));
    check({tag, "_ss_done"}, 64'(ss[0]), 64'd1);
  endtask

  initial begin
    int n;
    logic [31:0] held;
    rst     = 2'b11;
    addr_en = 2'b00;
    rd_ack  = 2'b00;
    addr_d  = '0;
    resp    = '0;
    #1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_ss%0d", g), 64'(ss[g]), 64'd1);
      check($sformatf("rst_sck%0d", g), 64'(sck[g]), 64'd0);
      check($sformatf("rst_mosi%0d", g), 64'(mosi[g]), 64'd0);
      check($sformatf("rst_free%0d", g), 64'(free[g]), 64'd1);
      check($sformatf("rst_avail%0d", g), 64'(avail[g]), 64'd0);
      check($sformatf("rst_data%0d", g), 64'(rdd[g]), 64'd0);
    end
    repeat (3) @(negedge clk);
    rst = 2'b00;
    repeat (2) tick();

    // First request after reset carries the wake command.
    wake_then_read(24'h000010, 32'h11223344, "wake1");

    // Result held without acknowledge.
    held = rdd[0];
    repeat (50) tick();
    check("hold_avail", 64'(avail[0]), 64'd1);
    check("hold_data", 64'(rdd[0]), 64'(held));
    check("hold_free", 64'(free[0]), 64'd0);
    ack(0);

    // Second request: no wake, exact 256-clock latency, stray addr_en mid-frame ignored.
    resp[0] = 32'h00010203;
    request(0, 24'h100000);
    for (int i = 1; i <= 256; i++) begin
      if (i == 100) begin
        addr_en[0] = 1'b1;
        addr_d[0]  = 24'hFFFFFF;
      end
      tick();
      addr_en[0] = 1'b0;
      if (i == 1) check("no_wake_ss_low", 64'(ss[0]), 64'd0);
      if (i == 255) check("avail_early", 64'(avail[0]), 64'd0);
    end
    check("avail_256", 64'(avail[0]), 64'd1);
    check("mosi_100000", mosi_log[0], 64'h03100000_00000000);
    check("data_00010203", 64'(rdd[0]), 64'h00010203);
    ack(0);

    // HALF_PERIOD=1 instance.
    resp[1] = 32'hDEADBEEF;
    request(1, 24'hABCDEF);
    wait_avail(1, n);
    check("hp1_lat", 64'(n), 64'd128);
    check("hp1_mosi", mosi_log[1], 64'h03ABCDEF_00000000);
    check("hp1_data", 64'(rdd[1]), 64'hDEADBEEF);
    ack(1);

    // Reset in the middle of a read frame.
    resp[0] = 32'h55AA55AA;
    request(0, 24'h000020);
    n = 0;
    while (rcnt_a[0] != 8'd20 && n < 5000) begin
      tick();
      n++;
    end
    check("reach_bit20", 64'(rcnt_a[0]), 64'd20);
    rst[0] = 1'b1;
    #1;
    check("mid_rst_ss", 64'(ss[0]), 64'd1);
    check("mid_rst_sck", 64'(sck[0]), 64'd0);
    check("mid_rst_mosi", 64'(mosi[0]), 64'd0);
    check("mid_rst_free", 64'(free[0]), 64'd1);
    check("mid_rst_avail", 64'(avail[0]), 64'd0);
    check("mid_rst_data", 64'(rdd[0]), 64'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (2) tick();

    // Wake must be sent again after that reset.
    wake_then_read(24'h000040, 32'hCAFEF00D, "wake2");
    ack(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
